// File: rtl/lcd_ctrl.sv
// Write-only HD44780 character-LCD sequencer: one byte per valid/ready handshake,
// then setup / enable pulse / hold / execution wait. Define LCD_INIT_EN for the power-up init sequence.
module lcd_ctrl #(
    parameter int unsigned T_SETUP    = 2,
    parameter int unsigned T_EN_HIGH  = 12,
    parameter int unsigned T_HOLD     = 2,
    parameter int unsigned T_CMD_WAIT = 2000,
    parameter int unsigned T_CLR_WAIT = 82000,
    parameter int unsigned T_PWRUP    = 2000000,
    parameter int unsigned CNT_W      = 21
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    input  logic       cmd_rs_i,
    input  logic [7:0] cmd_data_i,
    output logic       cmd_ready_o,
    output logic [7:0] lcd_data_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_en_o
);

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, EN_HI, HOLD, WAIT} state_e;

`ifdef LCD_INIT_EN
    localparam state_e           RST_STATE = PWRUP;
    localparam logic [CNT_W-1:0] RST_CNT   = CNT_W'(T_PWRUP - 1);
`else
    localparam state_e           RST_STATE = IDLE;
    localparam logic [CNT_W-1:0] RST_CNT   = '0;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             en_q, en_d;
    logic             clr_wait;

    // Counter reload for a state entry: the state lasts exactly (value + 1) cycles.
    function automatic logic [CNT_W-1:0] load_cnt(input state_e s, input logic clr);
        case (s)
            PWRUP:   return CNT_W'(T_PWRUP - 1);
            SETUP:   return CNT_W'(T_SETUP - 1);
            EN_HI:   return CNT_W'(T_EN_HIGH - 1);
            HOLD:    return CNT_W'(T_HOLD - 1);
            WAIT:    return clr ? CNT_W'(T_CLR_WAIT - 1) : CNT_W'(T_CMD_WAIT - 1);
            default: return '0;
        endcase
    endfunction

`ifdef LCD_INIT_EN
    logic [2:0] init_left_q, init_left_d;

    function automatic logic [7:0] init_byte(input logic [2:0] left);
        case (left)
            3'd4:    return 8'h38;
            3'd3:    return 8'h0C;
            3'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        data_d   = data_q;
        rs_d     = rs_q;
        en_d     = en_q;
        clr_wait = !rs_q && (data_q[7:2] == 6'd0);
`ifdef LCD_INIT_EN
        init_left_d = init_left_q;
`endif

        case (state_q)
`ifdef LCD_INIT_EN
            PWRUP: if (cnt_q == '0) state_d = INIT;
            INIT: begin
                data_d      = init_byte(init_left_q);
                rs_d        = 1'b0;
                init_left_d = init_left_q - 3'd1;
                state_d     = SETUP;
            end
`endif
            IDLE: begin
                ready_d = 1'b1;
                if (cmd_valid_i && ready_q) begin
                    ready_d = 1'b0;
                    data_d  = cmd_data_i;
                    rs_d    = cmd_rs_i;
                    state_d = SETUP;
                end
            end
            SETUP: if (cnt_q == '0) begin
                state_d = EN_HI;
                en_d    = 1'b1;
            end
            EN_HI: if (cnt_q == '0) begin
                state_d = HOLD;
                en_d    = 1'b0;
            end
            HOLD: if (cnt_q == '0) state_d = WAIT;
            WAIT: if (cnt_q == '0) begin
`ifdef LCD_INIT_EN
                if (init_left_q != 3'd0) begin
                    state_d = INIT;
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
`else
                state_d = IDLE;
                ready_d = 1'b1;
`endif
            end
            default: state_d = RST_STATE;
        endcase

        if (state_d != state_q) begin
            cnt_d = load_cnt(state_d, clr_wait);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RST_STATE;
            cnt_q   <= RST_CNT;
            ready_q <= 1'b0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
        end
    end

`ifdef LCD_INIT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) init_left_q <= 3'd4;
        else         init_left_q <= init_left_d;
    end
`endif

    assign cmd_ready_o = ready_q;
    assign lcd_data_o  = data_q;
    assign lcd_rs_o    = rs_q;
    assign lcd_rw_o    = 1'b0;
    assign lcd_en_o    = en_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: randomized byte transfers against a timing/ordering model.
// Build with LCD_INIT_EN defined to exercise the power-up init sequence.
module tb_lcd_ctrl;

    localparam int T_SETUP    = 2;
    localparam int T_EN_HIGH  = 3;
    localparam int T_HOLD     = 1;
    localparam int T_CMD_WAIT = 5;
    localparam int T_CLR_WAIT = 10;
    localparam int T_PWRUP    = 20;
    localparam int BOUND      = 300;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rs = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         start;
        int         width;
    } pulse_t;

    pulse_t pulses[$];
    pulse_t cur;
    logic   en_prev = 1'b0;

    lcd_ctrl #(
        .T_SETUP   (T_SETUP),
        .T_EN_HIGH (T_EN_HIGH),
        .T_HOLD    (T_HOLD),
        .T_CMD_WAIT(T_CMD_WAIT),
        .T_CLR_WAIT(T_CLR_WAIT),
        .T_PWRUP   (T_PWRUP),
        .CNT_W     (21)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_rs_i   (cmd_rs),
        .cmd_data_i (cmd_data),
        .cmd_ready_o(cmd_ready),
        .lcd_data_o (lcd_data),
        .lcd_rs_o   (lcd_rs),
        .lcd_rw_o   (lcd_rw),
        .lcd_en_o   (lcd_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Records every EN pulse: byte on the bus at the rising edge, edge number, width in cycles.
    always @(negedge clk) begin
        if (lcd_en && !en_prev) begin
            cur.data  = lcd_data;
            cur.rs    = lcd_rs;
            cur.start = cyc;
        end else if (!lcd_en && en_prev) begin
            cur.width = cyc - cur.start;
            pulses.push_back(cur);
        end
        en_prev = lcd_en;
    end

    // Reference timing: cycles from accept edge to ready-high edge.
    function automatic int exp_latency(input logic rs, input logic [7:0] d);
        int w;
        w = (rs == 1'b0 && int'(d) < 4) ? T_CLR_WAIT : T_CMD_WAIT;
        return T_SETUP + T_EN_HIGH + T_HOLD + w;
    endfunction

    task automatic wait_ready(output int rise, output bit ok);
        ok = 1'b0;
        rise = -1;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                rise = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send(input logic rs, input logic [7:0] d, output int acc, output bit ok);
        cmd_valid = 1'b1;
        cmd_rs = rs;
        cmd_data = d;
        ok = 1'b0;
        acc = -1;
        for (int i = 0; i < BOUND; i++) begin
            if (cmd_ready === 1'b1) begin
                acc = cyc + 1;
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic run_xfer(input logic rs, input logic [7:0] d, input string name);
        int acc, rise;
        bit ok;
        pulse_t p;
        send(rs, d, acc, ok);
        checks++;
        if (!ok || lcd_data !== d || lcd_rs !== rs || cmd_ready !== 1'b0 || lcd_en !== 1'b0 || lcd_rw !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: ok=%0d data=%h rs=%b ready=%b en=%b rw=%b, want data=%h rs=%b ready=0 en=0 rw=0",
                     name, ok, lcd_data, lcd_rs, cmd_ready, lcd_en, lcd_rw, d, rs);
        end
        wait_ready(rise, ok);
        checks++;
        if (!ok || rise - acc != exp_latency(rs, d)) begin
            failures++;
            $display("FAIL %s latency: got %0d (ok=%0d), want %0d", name, rise - acc, ok, exp_latency(rs, d));
        end
        checks++;
        if (pulses.size() != 1) begin
            failures++;
            $display("FAIL %s pulse count: got %0d, want 1", name, pulses.size());
            pulses.delete();
        end else begin
            p = pulses.pop_front();
            if (p.start != acc + T_SETUP || p.width != T_EN_HIGH || p.data !== d || p.rs !== rs) begin
                failures++;
                $display("FAIL %s pulse: start=+%0d width=%0d data=%h rs=%b, want start=+%0d width=%0d data=%h rs=%b",
                         name, p.start - acc, p.width, p.data, p.rs, T_SETUP, T_EN_HIGH, d, rs);
            end
        end
    endtask

    task automatic test_init();
        int c0, rise;
        bit ok;
        logic [7:0] exp_b[4];
        pulse_t p[4];
        exp_b = '{8'h38, 8'h0C, 8'h01, 8'h06};
        c0 = cyc;
        cmd_valid = 1'b1;
        cmd_rs = 1'b1;
        cmd_data = 8'hFF;
        wait_ready(rise, ok);
        cmd_valid = 1'b0;
        checks++;
        if (!ok || rise - c0 <= T_PWRUP) begin
            failures++;
            $display("FAIL init ready: rose after %0d cycles (ok=%0d), want > %0d", rise - c0, ok, T_PWRUP);
        end
        checks++;
        if (pulses.size() != 4) begin
            failures++;
            $display("FAIL init pulse count: got %0d, want 4", pulses.size());
            pulses.delete();
        end else begin
            for (int i = 0; i < 4; i++) p[i] = pulses.pop_front();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (p[i].data !== exp_b[i] || p[i].rs !== 1'b0 || p[i].width != T_EN_HIGH) begin
                    failures++;
                    $display("FAIL init byte %0d: data=%h rs=%b width=%0d, want data=%h rs=0 width=%0d",
                             i, p[i].data, p[i].rs, p[i].width, exp_b[i], T_EN_HIGH);
                end
            end
            checks++;
            if (p[0].start < c0 + T_PWRUP + T_SETUP) begin
                failures++;
                $display("FAIL init first pulse: at +%0d, want >= +%0d", p[0].start - c0, T_PWRUP + T_SETUP);
            end
            checks++;
            if ((p[3].start - p[2].start) - (p[1].start - p[0].start) != T_CLR_WAIT - T_CMD_WAIT) begin
                failures++;
                $display("FAIL init clear gap: extra %0d, want %0d",
                         (p[3].start - p[2].start) - (p[1].start - p[0].start), T_CLR_WAIT - T_CMD_WAIT);
            end
            checks++;
            if (rise - (p[3].start + T_EN_HIGH) != T_HOLD + T_CMD_WAIT) begin
                failures++;
                $display("FAIL init final wait: got %0d, want %0d", rise - (p[3].start + T_EN_HIGH), T_HOLD + T_CMD_WAIT);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (cmd_ready !== 1'b0 || lcd_data !== 8'h00 || lcd_rs !== 1'b0 || lcd_rw !== 1'b0 || lcd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset values: ready=%b data=%h rs=%b rw=%b en=%b, want all 0",
                     cmd_ready, lcd_data, lcd_rs, lcd_rw, lcd_en);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || lcd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset held: ready=%b en=%b, want 0 0", cmd_ready, lcd_en);
        end
        rst_n = 1'b1;
`ifdef LCD_INIT_EN
        test_init();
`else
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset release ready: got %b, want 1", cmd_ready);
        end
`endif
    endtask

    task automatic test_random();
        logic rs;
        logic [7:0] d;
        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            run_xfer(rs, d, $sformatf("random%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[3];
        int acc[3];
        int idx, rise;
        bit ok;
        pulse_t p;
        b = '{8'h41, 8'h42, 8'h43};
        idx = 0;
        cmd_valid = 1'b1;
        cmd_rs = 1'b1;
        cmd_data = b[0];
        for (int i = 0; i < BOUND && idx < 3; i++) begin
            if (cmd_ready === 1'b1) begin
                acc[idx] = cyc + 1;
                idx++;
                @(negedge clk);
                if (idx < 3) cmd_data = b[idx];
                else cmd_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        wait_ready(rise, ok);
        checks++;
        if (idx != 3 || !ok) begin
            failures++;
            $display("FAIL b2b accepts: got %0d (ready ok=%0d), want 3", idx, ok);
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc[i] - acc[i-1] != exp_latency(1'b1, b[i-1]) + 1) begin
                    failures++;
                    $display("FAIL b2b spacing %0d: got %0d, want %0d", i, acc[i] - acc[i-1], exp_latency(1'b1, b[i-1]) + 1);
                end
            end
        end
        checks++;
        if (pulses.size() != 3) begin
            failures++;
            $display("FAIL b2b pulse count: got %0d, want 3", pulses.size());
            pulses.delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                p = pulses.pop_front();
                checks++;
                if (p.data !== b[i] || p.rs !== 1'b1 || p.width != T_EN_HIGH) begin
                    failures++;
                    $display("FAIL b2b byte %0d: data=%h rs=%b width=%0d, want data=%h rs=1 width=%0d",
                             i, p.data, p.rs, p.width, b[i], T_EN_HIGH);
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] a, x;
        logic xr;
        bit stable, got;
        int rise;
        bit ok;
        pulse_t p;
        a = 8'($urandom_range(4, 255));
        x = 8'h00;
        xr = 1'b0;
        stable = 1'b1;
        got = 1'b0;
        cmd_valid = 1'b1;
        cmd_rs = 1'b1;
        cmd_data = a;
        @(negedge clk);
        for (int i = 0; i < BOUND; i++) begin
            if (cmd_ready === 1'b1) begin
                x = 8'($urandom_range(0, 255));
                xr = 1'($urandom_range(0, 1));
                cmd_data = x;
                cmd_rs = xr;
                got = 1'b1;
                break;
            end
            if (lcd_data !== a || lcd_rs !== 1'b1) stable = 1'b0;
            cmd_data = 8'($urandom_range(0, 255));
            cmd_rs = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (!got || !stable || lcd_data !== x || lcd_rs !== xr) begin
            failures++;
            $display("FAIL busy ignore: got=%0d stable=%0d data=%h rs=%b, want data=%h rs=%b",
                     got, stable, lcd_data, lcd_rs, x, xr);
        end
        wait_ready(rise, ok);
        checks++;
        if (!ok || pulses.size() != 2) begin
            failures++;
            $display("FAIL busy pulse count: got %0d (ok=%0d), want 2", pulses.size(), ok);
            pulses.delete();
        end else begin
            p = pulses.pop_front();
            if (p.data !== a) begin
                failures++;
                $display("FAIL busy first byte: got %h, want %h", p.data, a);
            end
            p = pulses.pop_front();
            if (p.data !== x || p.rs !== xr) begin
                failures++;
                $display("FAIL busy second byte: got %h/%b, want %h/%b", p.data, p.rs, x, xr);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        bit ok, hi;
        send(1'b1, 8'h55, acc, ok);
        hi = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            if (lcd_en === 1'b1) begin
                hi = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || !hi || lcd_en !== 1'b0 || cmd_ready !== 1'b0 || lcd_data !== 8'h00 || lcd_rs !== 1'b0) begin
            failures++;
            $display("FAIL reset mid: ok=%0d hi=%0d en=%b ready=%b data=%h rs=%b, want en=0 ready=0 data=00 rs=0",
                     ok, hi, lcd_en, cmd_ready, lcd_data, lcd_rs);
        end
        @(negedge clk);
        @(negedge clk);
        pulses.delete();
        rst_n = 1'b1;
`ifdef LCD_INIT_EN
        test_init();
`else
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || lcd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset mid release: ready=%b en=%b, want 1 0", cmd_ready, lcd_en);
        end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        run_xfer(1'b1, 8'h41, "data_41");
        run_xfer(1'b0, 8'h01, "clear_01");
        run_xfer(1'b0, 8'h80, "ddram_80");
        run_xfer(1'b0, 8'h03, "home_03");
        run_xfer(1'b0, 8'h04, "entry_04");
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        run_xfer(1'b1, 8'h5A, "after_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Write-only HD44780 character-LCD sequencer that sits behind the pipeline's memory-mapped LCD output register. It accepts one command or data byte at a time over a valid/ready handshake, then drives the LCD pins with the required setup, enable-pulse, hold and execution-wait timing. It also reports when the next byte may be sent. An optional power-on initialisation sequence can be compiled in.

## Interface
Parameters (all cycle counts, each ≥ 1; defaults sized for a 50 MHz clock):
- T_SETUP, 2, cycles RS/data are stable before EN rises
- T_EN_HIGH, 12, cycles EN is held high
- T_HOLD, 2, cycles RS/data are held after EN falls
- T_CMD_WAIT, 2000, execution wait after a normal command or data write
- T_CLR_WAIT, 82000, execution wait after clear/home (RS=0, data 0x01–0x03)
- T_PWRUP, 2000000, power-up delay before the init sequence (used only with LCD_INIT_EN)
- CNT_W, 21, counter width; must hold the largest count above

Ports:
- clk_i  in  1  clock; all state changes on its rising edge
- rst_ni  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  request to transfer one byte
- cmd_rs_i  in  1  register select; 0 = instruction, 1 = data
- cmd_data_i  in  8  byte to transfer
- cmd_ready_o  out  1  block can accept a byte this cycle
- lcd_data_o  out  8  LCD DB[7:0]
- lcd_rs_o  out  1  LCD RS
- lcd_rw_o  out  1  LCD RW; constant 0 (write-only)
- lcd_en_o  out  1  LCD E

## Operation
- Reset values: cmd_ready_o=0, lcd_data_o=0x00, lcd_rs_o=0, lcd_rw_o=0, lcd_en_o=0. All outputs are registered.
- States: PWRUP, INIT, IDLE, SETUP, EN_HI, HOLD, WAIT.
- Reset state is PWRUP with LCD_INIT_EN, otherwise IDLE.
- IDLE: cmd_ready_o=1. A transfer is accepted when cmd_valid_i and cmd_ready_o are both 1 at an edge.
  - On that edge, cmd_rs_i and cmd_data_i are latched onto lcd_rs_o and lcd_data_o.
  - cmd_ready_o goes to 0 and the state moves to SETUP.
  - A valid with ready low is ignored. The requester must hold it until accepted.
- SETUP: counts T_SETUP cycles, then goes to EN_HI with lcd_en_o=1.
- EN_HI: counts T_EN_HIGH cycles, then goes to HOLD with lcd_en_o=0.
- HOLD: counts T_HOLD cycles with lcd_rs_o and lcd_data_o unchanged, then goes to WAIT.
- WAIT: counts T_CLR_WAIT if the latched byte has rs=0 and data[7:2]==0; otherwise counts T_CMD_WAIT. Then:
  - returns to IDLE if no init entries remain;
  - otherwise returns to INIT.
- lcd_rs_o and lcd_data_o keep their last value in IDLE; they are not cleared.
- A single down-counter of CNT_W bits is loaded on each state entry with (count−1). It advances when it reaches 0. No wrap-around.

## Timing
- Accept at edge N: lcd_rs_o and lcd_data_o change at N.
  - lcd_en_o rises at edge N+T_SETUP.
  - lcd_en_o falls at edge N+T_SETUP+T_EN_HIGH.
- cmd_ready_o returns high at edge N+T_SETUP+T_EN_HIGH+T_HOLD+Twait, where Twait is T_CMD_WAIT or T_CLR_WAIT.
- Back-to-back: a byte held valid through that edge is accepted on the next edge. Minimum one IDLE cycle between transfers.
- Reset asserted mid-transfer clears everything immediately and asynchronously; lcd_en_o drops without waiting for the clock. After release, operation restarts from the reset state.

## Configuration
- LCD_INIT_EN defined:
  - After reset, PWRUP waits T_PWRUP cycles with cmd_ready_o=0.
  - INIT then issues the fixed instruction list 0x38, 0x0C, 0x01, 0x06 (all RS=0), each through SETUP..WAIT with normal wait selection (0x01 uses T_CLR_WAIT).
  - The state reaches IDLE only after the fourth byte's WAIT. External valids are ignored until then.
- LCD_INIT_EN undefined: no PWRUP or INIT logic; IDLE with cmd_ready_o=1 on the first edge after reset release.

## Test plan
Bench parameters: T_SETUP=2, T_EN_HIGH=3, T_HOLD=1, T_CMD_WAIT=5, T_CLR_WAIT=10, T_PWRUP=20.
- No-init build, send rs=1, data 0x41 -> data=0x41 and rs=1 at accept; EN high for exactly 3 cycles starting 2 cycles later; ready back 11 cycles after accept.
- Send rs=0, 0x01 -> ready back 16 cycles after accept. Send rs=0, 0x80 -> ready back 11 cycles after accept.
- Hold valid continuously with 0x41, 0x42, 0x43 -> exactly three EN pulses with data 0x41, 0x42, 0x43 in order; no byte dropped or duplicated.
- Valid asserted while busy, data changing each cycle -> ignored; only the byte present at the ready edge is driven.
- Reset asserted during EN_HI -> lcd_en_o=0 and cmd_ready_o=0 immediately; after release, ready is 1 on the first edge (no-init build).
- LCD_INIT_EN build -> ready low for 20 cycles, then EN pulses with 0x38, 0x0C, 0x01, 0x06 (rs=0). The gap after 0x01 is the clear wait. Ready rises after the last WAIT.
